ntt_coeff_packer: RTL and testbench

Serial-to-vector front end of the 8-point NTT datapath. Accepts one 8-bit coefficient per cycle over a valid/ready stream and packs each group of 8 into a 64-bit natural-order vector for the bit-reversal permutation stage. A ping-pong pair of vector banks lets one frame fill while the previous one waits for the consumer. Range and framing errors are flagged as sticky status.

---
 rtl/ntt_pkg.sv | 14 +
 rtl/ntt_pack_bank.sv | 46 ++++
 rtl/ntt_coeff_packer.sv | 103 ++++++++++
 tb/tb_ntt_coeff_packer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants.
// Used by the packer, bit-reversal and butterfly stages.
package ntt_pkg;

  localparam int COEFF_W = 8;
  localparam int N       = 8;
  localparam int LOG2N   = $clog2(N);
  localparam int VEC_W   = N * COEFF_W;
  localparam int Q       = 17;

  typedef logic [COEFF_W-1:0] coeff_t;
  typedef logic [VEC_W-1:0]   vec_t;

endpackage

// File: rtl/ntt_pack_bank.sv
// One N-slot coefficient bank with a full flag.
// Slots are addressed for write and read back as a flat vector.
module ntt_pack_bank
  import ntt_pkg::*;
#(
  parameter int BW = COEFF_W,
  parameter int BN = N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [$clog2(BN)-1:0] wr_slot,
  input  logic [BW-1:0]         wr_data,
  input  logic                  set_full,
  input  logic                  clr_full,
  output logic                  full,
  output logic [BN*BW-1:0]      vec
);

  logic [BN-1:0][BW-1:0] slot_q;
  logic                  full_q;

  assign vec  = slot_q;
  assign full = full_q;

  // slot storage; left intact on release, only the flag gates use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (wr_en) begin
      slot_q[wr_slot] <= wr_data;
    end
  end

  // full flag; set and clear never target the same bank together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else if (set_full) begin
      full_q <= 1'b1;
    end else if (clr_full) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ntt_coeff_packer.sv
// Serial-to-vector packer with ping-pong banks.
// Packs N coefficients into one natural-order vector.
module ntt_coeff_packer
  import ntt_pkg::*;
#(
  parameter int COEFF_W = ntt_pkg::COEFF_W,
  parameter int N       = ntt_pkg::N,
  parameter int Q       = ntt_pkg::Q
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COEFF_W-1:0]   in_coeff,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [N*COEFF_W-1:0] vec_out,
  output logic                 vec_valid,
  input  logic                 vec_ready,
  output logic                 err_range,
  output logic                 err_frame,
  input  logic                 err_clr
);

  localparam int LW = $clog2(N);
  localparam int VW = N * COEFF_W;
  localparam logic [LW-1:0] LAST_SLOT = LW'(N - 1);
  localparam logic [COEFF_W:0] QV = (COEFF_W + 1)'(Q);

  logic [LW-1:0]      cnt;
  logic               wr_sel;
  logic               rd_sel;
  logic [1:0]         full;
  logic [1:0][VW-1:0] bank_vec;

  logic acc;
  logic out_hs;
  logic last_slot;
  logic range_hit;
  logic frame_hit;

  assign in_ready  = !full[wr_sel];
  assign acc       = in_valid && in_ready;
  assign last_slot = (cnt == LAST_SLOT);
  assign vec_valid = full[rd_sel];
  assign out_hs    = vec_valid && vec_ready;
  assign vec_out   = bank_vec[rd_sel];

  assign range_hit = acc && ({1'b0, in_coeff} >= QV);
  assign frame_hit = acc && (in_last != last_slot);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ntt_pack_bank #(
      .BW (COEFF_W),
      .BN (N)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (acc && (wr_sel == 1'(b))),
      .wr_slot  (cnt),
      .wr_data  (in_coeff),
      .set_full (acc && last_slot && (wr_sel == 1'(b))),
      .clr_full (out_hs && (rd_sel == 1'(b))),
      .full     (full[b]),
      .vec      (bank_vec[b])
    );
  end

  // slot counter and fill-bank select; frame length fixed by count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      wr_sel <= 1'b0;
    end else if (acc) begin
      if (last_slot) begin
        cnt    <= '0;
        wr_sel <= !wr_sel;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // presented-bank select advances on each output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel <= 1'b0;
    end else if (out_hs) begin
      rd_sel <= !rd_sel;
    end
  end

  // sticky errors; a new error beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_range <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      err_range <= range_hit | (err_range & !err_clr);
      err_frame <= frame_hit | (err_frame & !err_clr);
    end
  end

endmodule

// File: tb/tb_ntt_coeff_packer.sv
// Directed bench for ntt_coeff_packer.
// Table of frames plus hand-written corner sequences.
module tb_ntt_coeff_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_coeff = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [63:0] vec_out;
  logic        vec_valid;
  logic        vec_ready = 1'b0;
  logic        err_range;
  logic        err_frame;
  logic        err_clr = 1'b0;

  int passed = 0;
  int total  = 0;
  logic [63:0] got[$];

  ntt_coeff_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_coeff  (in_coeff),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .vec_out   (vec_out),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .err_range (err_range),
    .err_frame (err_frame),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (vec_valid && vec_ready) got.push_back(vec_out);

  typedef struct {
    string       name;
    logic [63:0] c;
    int          last_at;
    logic [63:0] exp;
    int          er_at;
    int          ef_at;
  } frame_t;

  frame_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] c, input logic l);
    int w = 0;
    in_coeff = c;
    in_valid = 1'b1;
    in_last  = l;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) chk("beat_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic clr_errs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    logic [63:0] v0;
    int bad_rdy;
    int bad_vec;
    int w;

    tbl[0] = '{"ramp", 64'h0706050403020100, 7,
               64'h0706050403020100, 8, 8};
    tbl[1] = '{"range_s3", 64'h0807060511030201, 7,
               64'h0807060511030201, 3, 8};
    tbl[2] = '{"early_last", 64'h100F0E0D0C0B0A09, 4,
               64'h100F0E0D0C0B0A09, 8, 4};
    tbl[3] = '{"no_last", 64'h1010101010101010, 8,
               64'h1010101010101010, 8, 7};
    tbl[4] = '{"ff_s7", 64'hFF00000000000000, 7,
               64'hFF00000000000000, 7, 8};

    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_vec_valid", 64'(vec_valid), 64'd0);
    chk("rst_vec_out", vec_out, 64'd0);
    chk("rst_err_range", 64'(err_range), 64'd0);
    chk("rst_err_frame", 64'(err_frame), 64'd0);
    rst_n = 1'b1;
    tick();
    vec_ready = 1'b1;

    for (int i = 0; i < 5; i++) begin
      clr_errs();
      got.delete();
      chk({tbl[i].name, "_clr"}, 64'(err_range | err_frame), 64'd0);
      for (int k = 0; k < 8; k++) begin
        beat(tbl[i].c[k*8 +: 8], k == tbl[i].last_at);
        chk({tbl[i].name, "_er"}, 64'(err_range),
            64'(k >= tbl[i].er_at));
        chk({tbl[i].name, "_ef"}, 64'(err_frame),
            64'(k >= tbl[i].ef_at));
        if (k == 6) chk({tbl[i].name, "_early_vv"}, 64'(vec_valid), 64'd0);
      end
      chk({tbl[i].name, "_vv"}, 64'(vec_valid), 64'd1);
      chk({tbl[i].name, "_vec"}, vec_out, tbl[i].exp);
      tick();
      chk({tbl[i].name, "_vv_drop"}, 64'(vec_valid), 64'd0);
      chk({tbl[i].name, "_nvec"}, 64'(got.size()), 64'd1);
      if (got.size() > 0) chk({tbl[i].name, "_got"}, got[0], tbl[i].exp);
    end

    // error set in the same cycle as err_clr must win
    clr_errs();
    got.delete();
    err_clr = 1'b1;
    beat(8'h20, 1'b0);
    chk("clr_vs_err", 64'(err_range), 64'd1);
    beat(8'h01, 1'b0);
    chk("clr_later", 64'(err_range), 64'd0);
    err_clr = 1'b0;
    for (int k = 2; k < 8; k++) beat(8'h02, k == 7);
    tick();
    chk("clr_seq_vec", (got.size() > 0) ? got[0] : 64'hX,
        64'h0202020202020120);

    // both banks full under backpressure
    vec_ready = 1'b0;
    got.delete();
    for (int k = 1; k <= 16; k++) beat(8'(k), (k % 8) == 0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_vv", 64'(vec_valid), 64'd1);
    chk("bp_vec", vec_out, 64'h0807060504030201);
    v0 = vec_out;
    bad_rdy = 0;
    bad_vec = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (in_ready !== 1'b0) bad_rdy++;
      if (vec_out !== v0) bad_vec++;
    end
    chk("bp_hold_rdy", 64'(bad_rdy), 64'd0);
    chk("bp_hold_vec", 64'(bad_vec), 64'd0);
    vec_ready = 1'b1;
    tick();
    chk("bp_rdy_back", 64'(in_ready), 64'd1);
    w = 0;
    while (got.size() < 2 && w < 10) begin
      tick();
      w++;
    end
    chk("bp_nvec", 64'(got.size()), 64'd2);
    if (got.size() >= 2) begin
      chk("bp_first", got[0], 64'h0807060504030201);
      chk("bp_second", got[1], 64'h100F0E0D0C0B0A09);
    end

    // asynchronous reset mid-frame
    clr_errs();
    for (int k = 0; k < 4; k++) beat(8'h12, 1'b0);
    chk("pre_rst_er", 64'(err_range), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_vv", 64'(vec_valid), 64'd0);
    chk("arst_vec", vec_out, 64'd0);
    chk("arst_err", 64'({err_range, err_frame}), 64'd0);
    tick();
    rst_n = 1'b1;
    got.delete();
    for (int k = 0; k < 8; k++) beat(8'h0A, k == 7);
    tick();
    tick();
    chk("post_rst_nvec", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("post_rst_vec", got[0], 64'h0A0A0A0A0A0A0A0A);
    chk("post_rst_err", 64'({err_range, err_frame}), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
